pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL expose parameter DATA_W, default 96, meaning payload data width (alu_res, dmem write data, pc+4).
REQ-002 SHALL expose parameter CTRL_W, default 11, meaning control field width (write enable, wb select, write width); these bits are zeroed in bubbles.
REQ-003 SHALL expose parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single register with combinational in_ready.
REQ-004 sys_clk  input  1  clock; all state changes on the rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control field.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 out_valid  output  1  downstream entry present.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_ctrl  output  CTRL_W  registered control field.
REQ-014 out_data  output  DATA_W  registered data payload.
REQ-015 occupancy  output  2  held entries, 0..2.
REQ-016 stall_cnt  output  16  saturating count of backpressured cycles.

Function
REQ-017 Accept SHALL mean in_valid && in_ready; fire SHALL mean out_valid && out_ready.
REQ-018 States SHALL be EMPTY (occupancy 0), ONE (main entry valid, occupancy 1), FULL (main + skid valid, occupancy 2); FULL SHALL be unreachable when SKID=0.
REQ-019 EMPTY: accept -> ONE, main loaded from input; otherwise stay.
REQ-020 ONE: accept && fire -> ONE, main reloaded; accept && !fire -> FULL, skid loaded (SKID=1 only); !accept && fire -> EMPTY; neither -> hold.
REQ-021 FULL: fire -> ONE, main loaded from skid, skid cleared; no fire -> hold; no accept possible.
REQ-022 SKID=1: in_ready SHALL equal !(state==FULL), a direct register output, no combinational path from out_ready.
REQ-023 SKID=0: in_ready SHALL equal !out_valid || out_ready.
REQ-024 Latency SHALL be 1 cycle: entry accepted at edge N is visible on out_* after edge N when stage was EMPTY or firing.
REQ-025 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-026 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-027 When out_valid=0, out_ctrl SHALL be all-zero; out_data SHALL hold its last value.
REQ-028 flush SHALL override all other events: next state EMPTY, out_ctrl and skid ctrl zeroed, any same-cycle accept discarded, fire ignored for ordering purposes.
REQ-029 in_ready SHALL stay at its normal value during flush; an in_valid that cycle is consumed and discarded.
REQ-030 stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready && !flush, saturating at 16'hFFFF; SHALL never wrap; cleared only by reset.
REQ-031 occupancy SHALL be registered and match state encoding 0/1/2.

Reset
REQ-032 sys_rst low SHALL immediately force state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, occupancy 0, stall_cnt 0, independent of sys_clk.
REQ-033 During reset in_ready SHALL be 1 (both SKID values); no accept SHALL take effect while sys_rst is low.
REQ-034 Reset asserted mid-transfer (FULL or ONE) SHALL discard all entries; first edge after deassertion behaves as from EMPTY.

Verification
REQ-035 SKID=1, out_ready=1, stream in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, occupancy 1, stall_cnt 0.
REQ-036 SKID=1, accept A=0xA then out_ready=0 and accept B=0xB -> occupancy 2, in_ready 0; raise out_ready -> out A then B on consecutive cycles, in_ready returns 1 after A fires.
REQ-037 FULL with in_ctrl=11'h7FF held, assert flush one cycle with in_valid=1 -> next cycle out_valid 0, out_ctrl 0, occupancy 0; flushed input never appears.
REQ-038 SKID=0, out_ready=0 with ONE -> in_ready 0 combinationally; out_ready=1 same cycle in_valid=1 -> pass-through, occupancy stays 1.
REQ-039 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt reaches 16'hFFFF and remains there.
REQ-040 Assert sys_rst low between clock edges while FULL -> outputs clear before next edge; after release, in_ready 1, occupancy 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Pipeline stage register with optional two-entry skid buffer,
//               flush squash and saturating backpressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 11,
    parameter int SKID   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [15:0]         r_stall_cnt;

    logic                w_accept;
    logic                w_fire;

    assign w_accept = in_valid && in_ready;
    assign w_fire   = r_valid && out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_EMPTY;
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_data      <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // Squash wins over any accept or fire in the same cycle; data is
            // left in place because only the control bits carry side effects.
            r_state     <= ST_EMPTY;
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_ONE;
                        r_valid <= 1'b1;
                        r_ctrl  <= in_ctrl;
                        r_data  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        r_ctrl <= in_ctrl;
                        r_data <= in_data;
                    end else if (w_accept && (SKID != 0)) begin
                        r_state     <= ST_FULL;
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                    end else if (w_fire) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end
                end
                ST_FULL: begin
                    if (w_fire) begin
                        r_state     <= ST_ONE;
                        r_ctrl      <= r_skid_ctrl;
                        r_data      <= r_skid_data;
                        r_skid_ctrl <= '0;
                        r_skid_data <= '0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic w_to_full;
            logic r_in_ready;

            // Mirrors the next-state decision so in_ready never depends on out_ready.
            assign w_to_full = !flush &&
                               (((r_state == ST_ONE)  && w_accept && !w_fire) ||
                                ((r_state == ST_FULL) && !w_fire));

            always_ff @(posedge sys_clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= !w_to_full;
                end
            end

            assign in_ready = r_in_ready;
        end else begin : g_no_skid
            assign in_ready = !r_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_stall_cnt <= 16'd0;
        end else if (r_valid && !out_ready && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_data  = r_data;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Testbench for pipe_skid_reg: one SKID=1 and one SKID=0 instance, table
// vectors for state/handshake, a scoreboard queue for data ordering.
module tb_pipe_skid_reg;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // SKID=1 instance (a_*) and SKID=0 instance (b_*)
    logic        a_iv = 1'b0, a_ord = 1'b0, a_fl = 1'b0;
    logic [10:0] a_ctrl = '0;
    logic [95:0] a_data = '0;
    logic        a_ir, a_ov;
    logic [10:0] a_octrl;
    logic [95:0] a_odata;
    logic [1:0]  a_occ;
    logic [15:0] a_st;

    logic        b_iv = 1'b0, b_ord = 1'b0, b_fl = 1'b0;
    logic [10:0] b_ctrl = '0;
    logic [95:0] b_data = '0;
    logic        b_ir, b_ov;
    logic [10:0] b_octrl;
    logic [95:0] b_odata;
    logic [1:0]  b_occ;
    logic [15:0] b_st;

    pipe_skid_reg #(.DATA_W(96), .CTRL_W(11), .SKID(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_ctrl(a_ctrl), .in_data(a_data),
        .out_valid(a_ov), .out_ready(a_ord), .out_ctrl(a_octrl), .out_data(a_odata),
        .occupancy(a_occ), .stall_cnt(a_st)
    );

    pipe_skid_reg #(.DATA_W(96), .CTRL_W(11), .SKID(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_ctrl), .in_data(b_data),
        .out_valid(b_ov), .out_ready(b_ord), .out_ctrl(b_octrl), .out_data(b_odata),
        .occupancy(b_occ), .stall_cnt(b_st)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: push on accept, pop and compare on fire, clear on flush/reset.
    logic [106:0] q1[$];
    logic [106:0] q0[$];

    always @(negedge sys_clk) begin
        logic [106:0] e;
        if (!sys_rst || a_fl) begin
            q1.delete();
        end else begin
            if (a_ov && a_ord) begin
                chk("sb1_entry_expected", 128'(q1.size() != 0), 128'(1));
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("sb1_out", 128'({a_octrl, a_odata}), 128'(e));
                end
            end
            if (a_iv && a_ir) q1.push_back({a_ctrl, a_data});
        end
    end

    always @(negedge sys_clk) begin
        logic [106:0] e;
        if (!sys_rst || b_fl) begin
            q0.delete();
        end else begin
            if (b_ov && b_ord) begin
                chk("sb0_entry_expected", 128'(q0.size() != 0), 128'(1));
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("sb0_out", 128'({b_octrl, b_odata}), 128'(e));
                end
            end
            if (b_iv && b_ir) q0.push_back({b_ctrl, b_data});
        end
    end

    typedef struct {
        logic        iv;
        logic        ord;
        logic        fl;
        logic [95:0] data;
        logic [10:0] ctrl;
        logic        e_ir;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic [15:0] e_st;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic ord, input logic fl,
                                input logic [95:0] data, input logic [10:0] ctrl,
                                input logic e_ir, input logic e_ov,
                                input logic [1:0] e_occ, input logic [15:0] e_st);
        vec_t v;
        v.iv = iv; v.ord = ord; v.fl = fl; v.data = data; v.ctrl = ctrl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    // Inputs applied for one cycle; in_ready checked mid-cycle, state after the edge.
    task automatic run_vec(input int sel, input int idx, input vec_t v);
        if (sel == 1) begin
            a_iv = v.iv; a_ord = v.ord; a_fl = v.fl; a_data = v.data; a_ctrl = v.ctrl;
        end else begin
            b_iv = v.iv; b_ord = v.ord; b_fl = v.fl; b_data = v.data; b_ctrl = v.ctrl;
        end
        @(negedge sys_clk);
        chk($sformatf("t%0d[%0d].in_ready", sel, idx), 128'((sel == 1) ? a_ir : b_ir), 128'(v.e_ir));
        @(posedge sys_clk);
        #1;
        chk($sformatf("t%0d[%0d].out_valid", sel, idx), 128'((sel == 1) ? a_ov : b_ov), 128'(v.e_ov));
        chk($sformatf("t%0d[%0d].occupancy", sel, idx), 128'((sel == 1) ? a_occ : b_occ), 128'(v.e_occ));
        chk($sformatf("t%0d[%0d].stall_cnt", sel, idx), 128'((sel == 1) ? a_st : b_st), 128'(v.e_st));
        if (!v.e_ov)
            chk($sformatf("t%0d[%0d].out_ctrl_zero", sel, idx),
                128'((sel == 1) ? a_octrl : b_octrl), 128'(0));
    endtask

    vec_t t1[15];
    vec_t t0[6];

    initial begin
        //          iv ord fl data       ctrl     | ir ov occ stall
        t1[0]  = mk(1, 1, 0, 96'h1,  11'h001, 1, 1, 2'd1, 16'd0);
        t1[1]  = mk(1, 1, 0, 96'h2,  11'h002, 1, 1, 2'd1, 16'd0);
        t1[2]  = mk(1, 1, 0, 96'h3,  11'h003, 1, 1, 2'd1, 16'd0);
        t1[3]  = mk(0, 1, 0, 96'h0,  11'h000, 1, 0, 2'd0, 16'd0);
        t1[4]  = mk(1, 1, 0, 96'hA,  11'h005, 1, 1, 2'd1, 16'd0);
        t1[5]  = mk(1, 0, 0, 96'hB,  11'h006, 1, 1, 2'd2, 16'd1);
        t1[6]  = mk(1, 0, 0, 96'hC,  11'h007, 0, 1, 2'd2, 16'd2);
        t1[7]  = mk(0, 1, 0, 96'h0,  11'h000, 0, 1, 2'd1, 16'd2);
        t1[8]  = mk(0, 1, 0, 96'h0,  11'h000, 1, 0, 2'd0, 16'd2);
        t1[9]  = mk(1, 0, 0, 96'h11, 11'h7FF, 1, 1, 2'd1, 16'd2);
        t1[10] = mk(1, 0, 0, 96'h12, 11'h7FF, 1, 1, 2'd2, 16'd3);
        t1[11] = mk(1, 0, 1, 96'h13, 11'h7FF, 0, 0, 2'd0, 16'd3);
        t1[12] = mk(1, 0, 0, 96'h14, 11'h7FF, 1, 1, 2'd1, 16'd3);
        t1[13] = mk(1, 1, 1, 96'h15, 11'h7FF, 1, 0, 2'd0, 16'd3);
        t1[14] = mk(0, 1, 0, 96'h0,  11'h000, 1, 0, 2'd0, 16'd3);

        t0[0]  = mk(1, 0, 0, 96'h21, 11'h001, 1, 1, 2'd1, 16'd0);
        t0[1]  = mk(1, 0, 0, 96'h22, 11'h002, 0, 1, 2'd1, 16'd1);
        t0[2]  = mk(1, 1, 0, 96'h22, 11'h002, 1, 1, 2'd1, 16'd1);
        t0[3]  = mk(1, 1, 0, 96'h23, 11'h003, 1, 1, 2'd1, 16'd1);
        t0[4]  = mk(1, 1, 1, 96'h24, 11'h7FF, 1, 0, 2'd0, 16'd1);
        t0[5]  = mk(0, 1, 0, 96'h0,  11'h000, 1, 0, 2'd0, 16'd1);

        // Reset state, with upstream offering data that must not be taken
        sys_rst = 1'b0;
        a_iv = 1'b1; a_data = 96'hDEAD; b_iv = 1'b1; b_data = 96'hBEEF;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst.a_in_ready", 128'(a_ir), 128'(1));
        chk("rst.b_in_ready", 128'(b_ir), 128'(1));
        chk("rst.a_out_valid", 128'(a_ov), 128'(0));
        chk("rst.a_occupancy", 128'(a_occ), 128'(0));
        chk("rst.a_out", 128'({a_octrl, a_odata}), 128'(0));
        chk("rst.a_stall", 128'(a_st), 128'(0));
        chk("rst.b_occupancy", 128'(b_occ), 128'(0));
        chk("rst.b_out", 128'({b_octrl, b_odata}), 128'(0));
        a_iv = 1'b0; b_iv = 1'b0;
        sys_rst = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(1, i, t1[i]);
        for (int i = 0; i < 6; i++)  run_vec(0, i, t0[i]);

        // SKID=0: in_ready follows out_ready within the same cycle
        b_iv = 1'b1; b_data = 96'h31; b_ctrl = 11'h031; b_ord = 1'b0;
        @(posedge sys_clk);
        #1;
        b_iv = 1'b0;
        #1;
        chk("comb.in_ready_low", 128'(b_ir), 128'(0));
        b_ord = 1'b1;
        #1;
        chk("comb.in_ready_high", 128'(b_ir), 128'(1));
        @(posedge sys_clk);
        #1;
        chk("comb.drained", 128'(b_occ), 128'(0));

        // Stall counter saturation on the SKID=1 instance
        a_iv = 1'b1; a_data = 96'h99; a_ctrl = 11'h009; a_ord = 1'b0;
        @(posedge sys_clk);
        #1;
        a_iv = 1'b0;
        repeat (70000) @(posedge sys_clk);
        #1;
        chk("sat.stall_max", 128'(a_st), 128'(16'hFFFF));
        repeat (3) @(posedge sys_clk);
        #1;
        chk("sat.stall_held", 128'(a_st), 128'(16'hFFFF));
        chk("sat.occupancy", 128'(a_occ), 128'(1));

        // Asynchronous reset while FULL
        a_iv = 1'b1; a_data = 96'h9A; a_ctrl = 11'h00A;
        @(posedge sys_clk);
        #1;
        a_iv = 1'b0;
        chk("full.occupancy", 128'(a_occ), 128'(2));
        chk("full.in_ready", 128'(a_ir), 128'(0));
        #2;
        sys_rst = 1'b0;
        #1;
        chk("arst.out_valid", 128'(a_ov), 128'(0));
        chk("arst.occupancy", 128'(a_occ), 128'(0));
        chk("arst.out", 128'({a_octrl, a_odata}), 128'(0));
        chk("arst.stall", 128'(a_st), 128'(0));
        chk("arst.in_ready", 128'(a_ir), 128'(1));
        a_iv = 1'b1; a_data = 96'h5555; a_ord = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("arst.no_accept", 128'(a_occ), 128'(0));
        a_iv = 1'b0;
        sys_rst = 1'b1;
        #1;
        chk("rel.in_ready", 128'(a_ir), 128'(1));
        chk("rel.occupancy", 128'(a_occ), 128'(0));

        a_iv = 1'b1; a_data = 96'h77; a_ctrl = 11'h001;
        @(posedge sys_clk);
        #1;
        a_iv = 1'b0;
        chk("post.occupancy", 128'(a_occ), 128'(1));
        @(posedge sys_clk);
        #1;
        chk("post.drained", 128'(a_occ), 128'(0));
        chk("post.sb1_empty", 128'(q1.size()), 128'(0));
        chk("post.sb0_empty", 128'(q0.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
